// File: rtl/fifo_ring_pkg.sv
// Shared limits, bank-index type and sizing helpers for the banked ring FIFO.
package fifo_ring_pkg;
   localparam int MAX_NBANKS     = 16;
   localparam int MAX_BANK_DEPTH = 16;

   typedef logic [$clog2(MAX_NBANKS)-1:0] bank_idx_t;

   function automatic int count_w(input int nbanks, input int depth);
      return $clog2(nbanks * depth + 1);
   endfunction

   function automatic bank_idx_t next_bank(input bank_idx_t cur, input int nbanks);
      return (int'(cur) == nbanks - 1) ? '0 : cur + bank_idx_t'(1);
   endfunction
endpackage

// File: rtl/fifo_bank.sv
// One circular-buffer bank: head is read combinationally (0-cycle read latency).
// push/pop are qualified by the caller against full/empty; storage is never reset.
module fifo_bank #(
   parameter int WIDTH      = 704,
   parameter int BANK_DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_dat,
   output logic [WIDTH-1:0] head_dat,
   output logic             full,
   output logic             empty
);
   localparam int PW = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
   localparam int OW = $clog2(BANK_DEPTH + 1);

   logic [WIDTH-1:0] mem [BANK_DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [OW-1:0]    occ;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(BANK_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= inc(wr_ptr);
         if (pop)  rd_ptr <= inc(rd_ptr);
         if (push && !pop)      occ <= occ + OW'(1);
         else if (pop && !push) occ <= occ - OW'(1);
      end
   end

   // Data-only storage; a stale slot is unreachable once pointers are cleared.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_dat;
   end

   assign head_dat = mem[rd_ptr];
   assign full     = (occ == OW'(BANK_DEPTH));
   assign empty    = (occ == '0);
endmodule

// File: rtl/fifo_ring_n.sv
// In-order FIFO of NBANKS round-robin banks; first word visible 1 cycle after enqueue.
// RDYs come from registered state only; no enq->deq bypass, no deq->enq pass-through when full.
module fifo_ring_n
   import fifo_ring_pkg::*;
#(
   parameter int WIDTH      = 704,
   parameter int NBANKS     = 2,
   parameter int BANK_DEPTH = 1,
   localparam int CNT_W     = count_w(NBANKS, BANK_DEPTH)
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             in_enq__ENA,
   input  logic [WIDTH-1:0] in_enq_v,
   output logic             in_enq__RDY,
   input  logic             out_deq__ENA,
   output logic             out_deq__RDY,
   output logic [WIDTH-1:0] out_first,
   output logic             out_first__RDY,
   input  logic             flush__ENA,
   output logic             flush__RDY,
   output logic [CNT_W-1:0] count
);
   localparam int SEL_W = $clog2(NBANKS);
   typedef logic [SEL_W-1:0] sel_t;

   if (NBANKS < 2 || NBANKS > MAX_NBANKS || BANK_DEPTH < 1 || BANK_DEPTH > MAX_BANK_DEPTH) begin : g_bad_cfg
      $error("fifo_ring_n: NBANKS or BANK_DEPTH out of range");
   end

   sel_t             wr_sel, rd_sel;
   logic [NBANKS-1:0] bank_full, bank_empty;
   logic [WIDTH-1:0] bank_head [NBANKS];
   logic             enq_fire, deq_fire;

   assign in_enq__RDY    = !bank_full[wr_sel];
   assign out_deq__RDY   = !bank_empty[rd_sel];
   assign out_first__RDY = out_deq__RDY;
   assign flush__RDY     = 1'b1;
   assign enq_fire       = in_enq__ENA && in_enq__RDY && !flush__ENA;
   assign deq_fire       = out_deq__ENA && out_deq__RDY && !flush__ENA;
   // Storage is unreset, so the head is masked to zero while the ring is empty.
   assign out_first      = out_deq__RDY ? bank_head[rd_sel] : '0;

   for (genvar i = 0; i < NBANKS; i++) begin : g_bank
      fifo_bank #(.WIDTH(WIDTH), .BANK_DEPTH(BANK_DEPTH)) u_bank (
         .clk      (CLK),
         .rst_n    (nRST),
         .clr      (flush__ENA),
         .push     (enq_fire && (wr_sel == sel_t'(i))),
         .pop      (deq_fire && (rd_sel == sel_t'(i))),
         .push_dat (in_enq_v),
         .head_dat (bank_head[i]),
         .full     (bank_full[i]),
         .empty    (bank_empty[i])
      );
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wr_sel <= '0;
         rd_sel <= '0;
         count  <= '0;
      end else if (flush__ENA) begin
         wr_sel <= '0;
         rd_sel <= '0;
         count  <= '0;
      end else begin
         if (enq_fire) wr_sel <= sel_t'(next_bank(bank_idx_t'(wr_sel), NBANKS));
         if (deq_fire) rd_sel <= sel_t'(next_bank(bank_idx_t'(rd_sel), NBANKS));
         if (enq_fire && !deq_fire)      count <= count + CNT_W'(1);
         else if (deq_fire && !enq_fire) count <= count - CNT_W'(1);
      end
   end
endmodule
